// File: rtl/cavlc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cavlc_pkg
// Description : Shared types, constants and helpers for the CAVLC block
//               statistics engine.
// Revision    : 1.0 - initial release
// ============================================================================
package cavlc_pkg;

  // Legal coefficient counts per residual block
  localparam int MAX_COEFF_CHROMA_DC = 4;
  localparam int MAX_COEFF_AC        = 15;
  localparam int MAX_COEFF_FULL      = 16;

  // Widest count any legal block needs (0..16)
  localparam int STATS_CNT_W = $clog2(MAX_COEFF_FULL + 1);

  // Per-block statistics held in the output register
  typedef struct packed {
    logic [STATS_CNT_W-1:0] total_coeff;
    logic [1:0]             trailing_ones;
    logic [2:0]             t1_signs;
    logic [STATS_CNT_W-1:0] total_zeros;
    logic                   len_err;
  } cavlc_stats_t;

  // True when the (sign-extended) coefficient is +1 or -1
  function automatic logic abs_is_one(input logic signed [31:0] coeff);
    return (coeff == 32'sd1) || (coeff == -32'sd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_t1_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cavlc_t1_tracker
// Description : Tracks the TrailingOnes run of a block: the open flag, the
//               count (0..3) and the captured sign bits. The next-state
//               values are exported so the terminating beat can be folded
//               into the captured stats in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_t1_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       nz_beat,
  input  logic       is_one,
  input  logic       neg,
  output logic [1:0] t1_count_next,
  output logic [2:0] t1_signs_next
);

  logic       t1_open;
  logic       t1_open_next;
  logic [1:0] t1_count;
  logic [2:0] t1_signs;

  // Next state: a +/-1 extends the run while open, anything larger closes it
  always_comb begin
    t1_open_next  = t1_open;
    t1_count_next = t1_count;
    t1_signs_next = t1_signs;
    if (nz_beat) begin
      if (!is_one) begin
        t1_open_next = 1'b0;
      end else if (t1_open && (t1_count != 2'd3)) begin
        t1_count_next           = t1_count + 2'd1;
        t1_signs_next[t1_count] = neg;
      end
    end
  end

  // State register; clear reopens tracking for the next block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_open  <= 1'b1;
      t1_count <= 2'd0;
      t1_signs <= 3'd0;
    end else if (clear) begin
      t1_open  <= 1'b1;
      t1_count <= 2'd0;
      t1_signs <= 3'd0;
    end else begin
      t1_open  <= t1_open_next;
      t1_count <= t1_count_next;
      t1_signs <= t1_signs_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cavlc_block_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cavlc_block_stats
// Description : Streaming per-block CAVLC statistics. Consumes one residual
//               block in reverse zig-zag order and emits TotalCoeff,
//               TrailingOnes (+signs), TotalZeros and a length-error flag.
//               Optional run_before stream enabled by CAVLC_RUN_BEFORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_block_stats
  import cavlc_pkg::*;
#(
  parameter int COEFF_W   = 16,
  parameter int MAX_COEFF = 16,
  parameter int CNT_W     = $clog2(MAX_COEFF + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_coeff,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          total_coeff,
  output logic [1:0]                trailing_ones,
  output logic [2:0]                t1_signs,
  output logic [CNT_W-1:0]          total_zeros,
  output logic                      len_err
`ifdef CAVLC_RUN_BEFORE_EN
 ,output logic                      run_valid,
  output logic [CNT_W-1:0]          run_value
`endif
);

  localparam logic [STATS_CNT_W-1:0] LAST_IDX = STATS_CNT_W'(MAX_COEFF - 1);

  logic                   accept;
  logic                   is_nz;
  logic                   is_one;
  logic                   nz_beat;
  logic                   at_last_idx;
  logic                   term;
  logic                   clear;
  logic                   seen_nz;
  logic [STATS_CNT_W-1:0] beat_idx;
  logic [STATS_CNT_W-1:0] coeff_cnt;
  logic [STATS_CNT_W-1:0] zero_cnt;
  logic [1:0]             t1_count_next;
  logic [2:0]             t1_signs_next;
  cavlc_stats_t           stats_next;
  cavlc_stats_t           stats;

  // Only a pending, unaccepted result stalls the input
  assign in_ready    = !(out_valid && !out_ready);
  assign accept      = in_valid && in_ready && !blk_abort;
  assign is_nz       = (in_coeff != '0);
  assign is_one      = abs_is_one(32'(in_coeff));
  assign nz_beat     = accept && is_nz;
  assign at_last_idx = (beat_idx == LAST_IDX);
  // A block ends on in_last or when the final index arrives without it
  assign term        = accept && (in_last || at_last_idx);
  assign clear       = blk_abort || term;

  cavlc_t1_tracker u_t1 (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .nz_beat       (nz_beat),
    .is_one        (is_one),
    .neg           (in_coeff[COEFF_W-1]),
    .t1_count_next (t1_count_next),
    .t1_signs_next (t1_signs_next)
  );

  // Stats including the current beat; captured directly on termination
  always_comb begin
    stats_next.total_coeff   = coeff_cnt + STATS_CNT_W'(is_nz);
    stats_next.total_zeros   = zero_cnt + STATS_CNT_W'(!is_nz && seen_nz);
    stats_next.trailing_ones = t1_count_next;
    stats_next.t1_signs      = t1_signs_next;
    stats_next.len_err       = in_last ^ at_last_idx;
  end

  // Working counters for the block in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      seen_nz   <= 1'b0;
      coeff_cnt <= '0;
      zero_cnt  <= '0;
    end else if (clear) begin
      beat_idx  <= '0;
      seen_nz   <= 1'b0;
      coeff_cnt <= '0;
      zero_cnt  <= '0;
    end else if (accept) begin
      beat_idx  <= beat_idx + 1'b1;
      seen_nz   <= seen_nz || is_nz;
      coeff_cnt <= stats_next.total_coeff;
      zero_cnt  <= stats_next.total_zeros;
    end
  end

  // Output register; a new termination reloads even while being consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stats     <= '0;
      out_valid <= 1'b0;
    end else if (term) begin
      stats     <= stats_next;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign total_coeff   = stats.total_coeff[CNT_W-1:0];
  assign trailing_ones = stats.trailing_ones;
  assign t1_signs      = stats.t1_signs;
  assign total_zeros   = stats.total_zeros[CNT_W-1:0];
  assign len_err       = stats.len_err;

`ifdef CAVLC_RUN_BEFORE_EN
  logic                   run_a_valid;
  logic                   run_b_valid;
  logic [STATS_CNT_W-1:0] run_b_value;
  logic [STATS_CNT_W-1:0] run_cnt;
  logic                   pend_valid;
  logic [STATS_CNT_W-1:0] pend_value;
  logic                   run_valid_r;
  logic [STATS_CNT_W-1:0] run_value_r;

  // Run ending at a nonzero that follows an earlier nonzero
  assign run_a_valid = nz_beat && seen_nz;
  // Final run of the block: zeros trailing the last nonzero
  assign run_b_valid = term && (seen_nz || is_nz);
  assign run_b_value = is_nz ? '0 : (run_cnt + 1'b1);

  // Zero counter since the latest nonzero, plus a one-slot holding register
  // for the case where a nonzero terminating beat yields two runs at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      pend_valid  <= 1'b0;
      pend_value  <= '0;
      run_valid_r <= 1'b0;
      run_value_r <= '0;
    end else begin
      if (clear) begin
        run_cnt <= '0;
      end else if (accept) begin
        if (is_nz) begin
          run_cnt <= '0;
        end else if (seen_nz) begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
      if (pend_valid) begin
        run_valid_r <= 1'b1;
        run_value_r <= pend_value;
        pend_valid  <= run_a_valid || run_b_valid;
        pend_value  <= run_a_valid ? run_cnt : run_b_value;
      end else begin
        run_valid_r <= run_a_valid || run_b_valid;
        run_value_r <= run_a_valid ? run_cnt : run_b_value;
        pend_valid  <= run_a_valid && run_b_valid;
        pend_value  <= run_b_value;
      end
    end
  end

  assign run_valid = run_valid_r;
  assign run_value = run_value_r[CNT_W-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_cavlc_block_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cavlc_block_stats
// Description : Directed bench for cavlc_block_stats: table of blocks with
//               hand-computed stats, plus backpressure, abort and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cavlc_block_stats;

  localparam int COEFF_W   = 16;
  localparam int MAX_COEFF = 16;
  localparam int CNT_W     = 5;
  localparam int NV        = 9;
  localparam int NT        = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      blk_abort;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COEFF_W-1:0] in_coeff;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [CNT_W-1:0]          total_coeff;
  logic [1:0]                trailing_ones;
  logic [2:0]                t1_signs;
  logic [CNT_W-1:0]          total_zeros;
  logic                      len_err;
`ifdef CAVLC_RUN_BEFORE_EN
  logic                      run_valid;
  logic [CNT_W-1:0]          run_value;
  int                        runq[$];
`endif

  typedef struct {
    int len;
    bit last_flag;
    int tc;
    int t1;
    int signs;
    int tz;
    int le;
  } vec_t;

  vec_t vexp[NV];
  int   vcoef[NV][16];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cavlc_block_stats #(
    .COEFF_W   (COEFF_W),
    .MAX_COEFF (MAX_COEFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .blk_abort     (blk_abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coeff      (in_coeff),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .total_coeff   (total_coeff),
    .trailing_ones (trailing_ones),
    .t1_signs      (t1_signs),
    .total_zeros   (total_zeros),
    .len_err       (len_err)
`ifdef CAVLC_RUN_BEFORE_EN
   ,.run_valid     (run_valid),
    .run_value     (run_value)
`endif
  );

`ifdef CAVLC_RUN_BEFORE_EN
  always @(posedge clk) begin
    #2;
    if (run_valid) runq.push_back(int'(run_value));
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_stats(input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, "_out_valid"}, int'(out_valid), 1);
    chk({p, "_total_coeff"}, int'(total_coeff), vexp[idx].tc);
    chk({p, "_trailing_ones"}, int'(trailing_ones), vexp[idx].t1);
    chk({p, "_t1_signs"}, int'(t1_signs), vexp[idx].signs);
    chk({p, "_total_zeros"}, int'(total_zeros), vexp[idx].tz);
    chk({p, "_len_err"}, int'(len_err), vexp[idx].le);
  endtask

  // Drive one block; each beat is held until in_ready. Ends on the negedge
  // after the terminating beat with in_valid low.
  task automatic send_block(input int idx, input bit hold_after_first);
    int w;
    for (int k = 0; k < vexp[idx].len; k++) begin
      @(negedge clk);
      if (k == 1 && hold_after_first) out_ready = 1'b0;
      in_valid = 1'b1;
      in_coeff = 16'(vcoef[idx][k]);
      in_last  = (k == vexp[idx].len - 1) && vexp[idx].last_flag;
      #1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (!in_ready) chk($sformatf("v%0d_beat%0d_ready_timeout", idx, k), 0, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_coeff = '0;
  endtask

  initial begin
    int zz[16];
    int er[5];

    rst       = 1'b1;
    blk_abort = 1'b0;
    in_valid  = 1'b0;
    in_coeff  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Vector table: coefficients in stream order (highest frequency first)
    for (int i = 0; i < NV; i++)
      for (int k = 0; k < 16; k++) vcoef[i][k] = 0;

    zz = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) vcoef[0][k] = zz[15 - k];
    vexp[0] = '{16, 1'b1, 5, 3, 6, 3, 0};
    vexp[1] = '{16, 1'b1, 0, 0, 0, 0, 0};
    vcoef[2][11] = 1; vcoef[2][12] = 1; vcoef[2][13] = 1;
    vcoef[2][14] = 1; vcoef[2][15] = 2;
    vexp[2] = '{16, 1'b1, 5, 3, 0, 0, 0};
    vcoef[3][2] = 5; vcoef[3][4] = -1; vcoef[3][9] = 1;
    vexp[3] = '{10, 1'b1, 3, 0, 0, 5, 1};
    vcoef[4][0] = -1;
    vexp[4] = '{16, 1'b1, 1, 1, 1, 15, 0};
    for (int k = 0; k < 16; k++) vcoef[5][k] = 1;
    vexp[5] = '{16, 1'b0, 16, 3, 0, 0, 1};
    vcoef[6][0] = 1; vcoef[6][1] = -1; vcoef[6][2] = 1; vcoef[6][3] = -1;
    vexp[6] = '{16, 1'b1, 4, 3, 2, 12, 0};
    vcoef[7][0] = -2;
    vexp[7] = '{1, 1'b1, 1, 0, 0, 0, 1};
    vcoef[8][15] = 1;
    vexp[8] = '{16, 1'b1, 1, 1, 0, 0, 0};
    er = '{1, 0, 0, 1, 1};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_total_coeff", int'(total_coeff), 0);
    chk("reset_trailing_ones", int'(trailing_ones), 0);
    chk("reset_t1_signs", int'(t1_signs), 0);
    chk("reset_total_zeros", int'(total_zeros), 0);
    chk("reset_len_err", int'(len_err), 0);
`ifdef CAVLC_RUN_BEFORE_EN
    chk("reset_run_valid", int'(run_valid), 0);
`endif
    rst = 1'b0;

    // Table-driven blocks with out_ready held high
    for (int i = 0; i < NT; i++) begin
`ifdef CAVLC_RUN_BEFORE_EN
      runq.delete();
`endif
      send_block(i, 1'b0);
      check_stats(i);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid_clear", i), int'(out_valid), 0);
`ifdef CAVLC_RUN_BEFORE_EN
      repeat (2) @(negedge clk);
      if (i == 0) begin
        chk("v0_run_count", runq.size(), 5);
        for (int r = 0; r < 5 && r < runq.size(); r++)
          chk($sformatf("v0_run%0d", r), runq[r], er[r]);
      end
      if (i == 1) chk("v1_run_count", runq.size(), 0);
`endif
    end

    // Backpressure: first result held, input stalls, second follows
    out_ready = 1'b0;
    send_block(0, 1'b0);
    check_stats(0);
    chk("bp_in_ready_low_a", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    check_stats(0);
    chk("bp_in_ready_held", int'(in_ready), 0);
    out_ready = 1'b1;
    send_block(2, 1'b1);
    check_stats(2);
    chk("bp_in_ready_low_b", int'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_clear", int'(out_valid), 0);

    // Abort after five nonzero beats; coincident beat with in_last is dropped
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coeff = 16'((k == 0) ? 2 : ((k == 3) ? 3 : ((k % 2) ? -1 : 1)));
      in_last  = 1'b0;
    end
    @(negedge clk);
    blk_abort = 1'b1;
    in_coeff  = 16'(5);
    in_last   = 1'b1;
    @(negedge clk);
    blk_abort = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("abort_no_out_valid", int'(out_valid), 0);
    send_block(8, 1'b0);
    check_stats(8);

    // Reset mid-block discards the partial block
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coeff = 16'(2);
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_no_out_valid", int'(out_valid), 0);
    send_block(4, 1'b0);
    check_stats(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
